// File: rtl/switch_pulse_seq.sv
// Break-before-make S/R pulse sequencer for the photonic-switch RS flip-flop stage.
// Optional feature: define RETRIGGER_EN to let trigger edges in HOLD extend the hold time.
module switch_pulse_seq #(
  parameter int PULSE_W     = 4,
  parameter int HOLD_CYCLES = 100,
  parameter int DEAD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             enable,
  output logic             S,
  output logic             R,
  output logic             busy,
  output logic [CNT_W-1:0] missed
);

  localparam int MAX_PH = (PULSE_W > HOLD_CYCLES) ? PULSE_W : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_PH > DEAD_CYCLES) ? MAX_PH : DEAD_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SET, HOLD, RST, DEAD} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] missed_q, missed_d;
  logic             s_q, s_d, r_q, r_d, busy_q, busy_d;
  logic             ff1_q, ff2_q, ff3_q;
  logic             trig_edge;
  logic             count_miss;

  assign trig_edge = ff2_q & ~ff3_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    missed_d   = missed_q;
    count_miss = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig_edge && enable) begin
          state_d = SET;
          cnt_d   = CW'(PULSE_W);
        end
      end
      SET: begin
        count_miss = trig_edge;
        if (cnt_q == CW'(1)) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        // A retrigger takes priority over the hold expiring in the same cycle.
        if (RETRIG && trig_edge) begin
          cnt_d = CW'(HOLD_CYCLES);
        end else begin
          count_miss = trig_edge;
          if (cnt_q == CW'(1)) begin
            state_d = RST;
            cnt_d   = CW'(PULSE_W);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      RST: begin
        count_miss = trig_edge;
        if (cnt_q == CW'(1)) begin
          if (DEAD_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DEAD;
            cnt_d   = CW'(DEAD_CYCLES);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DEAD: begin
        count_miss = trig_edge;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (count_miss && (missed_q != '1)) begin
      missed_d = missed_q + CNT_W'(1);
    end

    // Outputs decode the next state so they change on the same edge as the state.
    s_d    = (state_d == SET);
    r_d    = (state_d == RST);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      missed_q <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      ff1_q    <= 1'b0;
      ff2_q    <= 1'b0;
      ff3_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      ff1_q    <= trig;
      ff2_q    <= ff1_q;
      ff3_q    <= ff2_q;
    end
  end

  assign S      = s_q;
  assign R      = r_q;
  assign busy   = busy_q;
  assign missed = missed_q;

endmodule

// File: tb/tb_switch_pulse_seq.sv
// Directed bench for switch_pulse_seq (PULSE_W=4, HOLD_CYCLES=10, DEAD_CYCLES=2, CNT_W=2).
// Cycle n means the interval just after rising clk edge n; trig bit n is driven in that interval.
module tb_switch_pulse_seq;

  localparam int P  = 4;
  localparam int H  = 10;
  localparam int D  = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          trig;
  logic          enable;
  logic          S;
  logic          R;
  logic          busy;
  logic [CW-1:0] missed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_pulse_seq #(
    .PULSE_W    (P),
    .HOLD_CYCLES(H),
    .DEAD_CYCLES(D),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .trig  (trig),
    .enable(enable),
    .S     (S),
    .R     (R),
    .busy  (busy),
    .missed(missed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; S and R must never be high together outside reset.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset === 1'b0) check("s_and_r_excl", 32'(S & R), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trig  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Runs one sequence whose first S cycle is s0, checking S/R/busy every cycle
  // against the ideal timing, and missed at the end.
  task automatic run_seq(input string tag, input logic [63:0] trig_pat,
                         input logic [63:0] en_pat, input int s0,
                         input int hold_len, input int exp_missed);
    int last;
    last   = s0 + 2 * P + hold_len + D;
    trig   = trig_pat[0];
    enable = en_pat[0];
    for (int n = 1; n <= last; n++) begin
      tick();
      trig   = trig_pat[n];
      enable = en_pat[n];
      check({tag, "_S"}, 32'(S), 32'(n >= s0 && n < s0 + P));
      check({tag, "_R"}, 32'(R), 32'(n >= s0 + P + hold_len && n < s0 + 2 * P + hold_len));
      check({tag, "_busy"}, 32'(busy), 32'(n >= s0 && n < last));
    end
    check({tag, "_missed"}, 32'(missed), 32'(exp_missed));
  endtask

  initial begin
    logic [63:0] all_on;
    all_on = '1;
    reset  = 1'b1;
    trig   = 1'b0;
    enable = 1'b1;

    // Reset state
    tick();
    check("rst_S", 32'(S), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_missed", 32'(missed), 32'd0);
    reset = 1'b0;
    tick();

    // Basic sequence: S after edge 3 for 4, hold 10, R 4, dead 2, idle at 23
    run_seq("basic", 64'h1, all_on, 3, H, 0);

    // Trig held high gives exactly one sequence
    run_seq("held", all_on, all_on, 3, H, 0);
    repeat (3) begin
      tick();
      check("held_no_second", 32'(busy), 32'd0);
    end
    trig = 1'b0;
    repeat (3) tick();

    // Edges during SET are counted in every build
    run_seq("set_miss", (64'd1 << 0) | (64'd1 << 2) | (64'd1 << 4), all_on, 3, H, 2);

`ifndef RETRIGGER_EN
    // Edges during HOLD are counted and leave R timing untouched
    do_reset();
    run_seq("hold_miss3", (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 7) | (64'd1 << 9),
            all_on, 3, H, 3);
    // Five edges with a 2-bit counter saturate at 3
    do_reset();
    run_seq("hold_sat", (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 7) | (64'd1 << 9) |
            (64'd1 << 11) | (64'd1 << 13), all_on, 3, H, 3);
`endif

    // Enable low in IDLE: edge ignored and not counted
    do_reset();
    enable = 1'b0;
    trig   = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    check("en_off_busy", 32'(busy), 32'd0);
    check("en_off_S", 32'(S), 32'd0);
    check("en_off_missed", 32'(missed), 32'd0);

    // Enable dropped during SET: the full sequence still completes
    run_seq("en_drop", 64'h1, 64'hF, 3, H, 0);
    enable = 1'b1;

    // Reset mid-HOLD clears everything with no R pulse
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (7) tick();
    check("mid_hold_busy", 32'(busy), 32'd1);
    check("mid_hold_missed", 32'(missed), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_S", 32'(S), 32'd0);
    check("midrst_R", 32'(R), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_missed", 32'(missed), 32'd0);
    reset = 1'b0;
    repeat (16) begin
      tick();
      check("post_rst_no_R", 32'(R), 32'd0);
    end

    // Edge on the first IDLE cycle starts a second sequence, nothing missed
    run_seq("b2b_first", (64'd1 << 0) | (64'd1 << 21), all_on, 3, H, 0);
    run_seq("b2b_second", 64'h0, all_on, 1, H, 0);

    // Edge in the last DEAD cycle is missed and starts nothing
    run_seq("late_edge", (64'd1 << 0) | (64'd1 << 20), all_on, 3, H, 1);
    repeat (4) begin
      tick();
      check("late_no_second", 32'(busy), 32'd0);
    end

`ifdef RETRIGGER_EN
    // Edge in HOLD cycle 6 reloads the hold (10 more cycles); edge in RST is missed
    do_reset();
    run_seq("retrig", (64'd1 << 0) | (64'd1 << 10) | (64'd1 << 22), all_on, 3, H + 6, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
